// File: rtl/bridge_pkg.sv
// Shared constants for the drawbridge sensor path: channel count, bit indices
// and default debounce tuning used by the conditioning stage and its integrator.
package bridge_pkg;
  localparam int NUM_SENSORS = 6;

  localparam int S1_IDX = 0;
  localparam int S2_IDX = 1;
  localparam int S3_IDX = 2;
  localparam int S4_IDX = 3;
  localparam int S5_IDX = 4;
  localparam int S6_IDX = 5;

  localparam int DEF_DEB_CYCLES  = 4;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_CHATTER_MAX = 3;

  // Startup counter width large enough to reach deb+2 without wrapping.
  function automatic int startup_w(input int deb);
    return $clog2(deb + 3);
  endfunction
endpackage

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: two-flop synchroniser, stability counter, rejected-bounce
// counter with sticky chatter flag, and a one-cycle change pulse.
module sensor_debounce_ch
  import bridge_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CHATTER_MAX = DEF_CHATTER_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic chg,
  output logic chatter
);
  localparam int BW = $clog2(CHATTER_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [BW-1:0]    BNC_MAX  = BW'(CHATTER_MAX);

  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;
  logic [BW-1:0]    bnc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      bnc     <= '0;
      stable  <= 1'b0;
      chg     <= 1'b0;
      chatter <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      chg   <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
          chg    <= 1'b1;
          bnc    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (cnt != '0) begin
        // Input fell back before the run completed: count it as a bounce.
        cnt <= '0;
        if (bnc != BNC_MAX) bnc <= bnc + BW'(1);
        if (bnc >= BNC_MAX - BW'(1)) chatter <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/sensor_debounce.sv
// Six-channel sensor conditioning for state_flat: per-channel debounce plus a
// post-reset settling counter that raises VALID once outputs can be trusted.
module sensor_debounce
  import bridge_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CHATTER_MAX = DEF_CHATTER_MAX
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NUM_SENSORS-1:0] RAW,
  output logic                   S1,
  output logic                   S2,
  output logic                   S3,
  output logic                   S4,
  output logic                   S5,
  output logic                   S6,
  output logic [NUM_SENSORS-1:0] CHG,
  output logic                   VALID,
  output logic [NUM_SENSORS-1:0] CHATTER
);
  localparam int SW = startup_w(DEB_CYCLES);
  localparam logic [SW-1:0] ST_LAST = SW'(DEB_CYCLES + 1);

  logic [NUM_SENSORS-1:0] s;
  logic [SW-1:0]          st_cnt;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_ch
    sensor_debounce_ch #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W),
      .CHATTER_MAX(CHATTER_MAX)
    ) u_ch (
      .clk    (Clock),
      .rst_n  (Reset),
      .raw    (RAW[i]),
      .stable (s[i]),
      .chg    (CHG[i]),
      .chatter(CHATTER[i])
    );
  end

  assign S1 = s[S1_IDX];
  assign S2 = s[S2_IDX];
  assign S3 = s[S3_IDX];
  assign S4 = s[S4_IDX];
  assign S5 = s[S5_IDX];
  assign S6 = s[S6_IDX];

  // Counter freezes once VALID is set, so it never wraps.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      st_cnt <= '0;
      VALID  <= 1'b0;
    end else if (!VALID) begin
      st_cnt <= st_cnt + SW'(1);
      if (st_cnt == ST_LAST) VALID <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sensor_debounce.sv
// Directed bench for sensor_debounce: window-based behavioural model checked
// every cycle, plus literal expectations at the key edges.
module tb_sensor_debounce;
  import bridge_pkg::*;

  localparam int DEB  = 4;
  localparam int CMAX = 3;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] RAW   = 6'b0;
  logic       S1, S2, S3, S4, S5, S6;
  logic [5:0] CHG, CHATTER;
  logic       VALID;
  logic [5:0] s_vec;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  sensor_debounce #(.DEB_CYCLES(DEB), .CNT_W(4), .CHATTER_MAX(CMAX)) dut (
    .Clock(Clock), .Reset(Reset), .RAW(RAW),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .S6(S6),
    .CHG(CHG), .VALID(VALID), .CHATTER(CHATTER)
  );

  always #5 Clock = ~Clock;
  assign s_vec = {S6, S5, S4, S3, S2, S1};

  // Model: a channel flips once its last DEB synchronised samples all differ
  // from the current level; a differing run that ends early is a bounce.
  logic [5:0]     m_s = '0, m_chg = '0, m_chat = '0;
  logic           m_valid = 1'b0;
  logic [5:0]     dly1 = '0, dly2 = '0, samp = '0;
  logic [DEB-1:0] win [6] = '{default: '0};
  int             bnc [6] = '{default: 0};
  int             edges = 0;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_s = '0; m_chg = '0; m_chat = '0; m_valid = 1'b0;
      dly1 = '0; dly2 = '0; edges = 0;
      for (int c = 0; c < 6; c++) begin
        win[c] = '0;
        bnc[c] = 0;
      end
    end else begin
      samp = dly2;
      dly2 = dly1;
      dly1 = RAW;
      m_chg = '0;
      for (int c = 0; c < 6; c++) begin
        win[c] = {win[c][DEB-2:0], samp[c]};
        if (win[c] == {DEB{~m_s[c]}}) begin
          m_s[c]   = ~m_s[c];
          m_chg[c] = 1'b1;
          bnc[c]   = 0;
        end else if (samp[c] == m_s[c] && win[c][1] != m_s[c]) begin
          bnc[c] = (bnc[c] < CMAX) ? bnc[c] + 1 : CMAX;
          if (bnc[c] == CMAX) m_chat[c] = 1'b1;
        end
      end
      edges++;
      m_valid = (edges >= DEB + 2);
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      tests++;
      if ({s_vec, CHG, VALID, CHATTER} !== {m_s, m_chg, m_valid, m_chat}) begin
        fails++;
        $display("FAIL model_cmp t=%0t S=%b exp %b CHG=%b exp %b VALID=%b exp %b CHATTER=%b exp %b",
                 $time, s_vec, m_s, CHG, m_chg, VALID, m_valid, CHATTER, m_chat);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clock);
      #1;
    end
  endtask

  initial begin
    // Reset and VALID
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check("rst_outputs", {s_vec, CHG, VALID, CHATTER}, 32'h0);
    Reset = 1'b1;
    tick(5);
    check("valid_pre", VALID, 0);
    tick(1);
    check("valid_edge6", VALID, 1);
    check("chg_idle", CHG, 0);

    // Clean accept on S1
    RAW = 6'b000001;
    tick(5);
    check("s1_pre", s_vec, 0);
    tick(1);
    check("s1_accept", s_vec, 6'b000001);
    check("s1_chg", CHG, 6'b000001);
    tick(1);
    check("s1_chg_one_cycle", CHG, 0);
    tick(3);

    // Glitch of DEB-1 samples rejected, DEB samples accepted
    RAW[1] = 1'b1;
    tick(3);
    RAW[1] = 1'b0;
    tick(8);
    check("s2_glitch3", s_vec, 6'b000001);
    check("s2_glitch_chatter", CHATTER, 0);
    RAW[1] = 1'b1;
    tick(4);
    RAW[1] = 1'b0;
    tick(2);
    check("s2_pulse4", s_vec, 6'b000011);
    tick(8);
    check("s2_return", s_vec, 6'b000001);

    // Chatter on S5: three 2-sample pulses
    for (int i = 0; i < 3; i++) begin
      if (i == 2) check("chatter_pre", CHATTER, 0);
      RAW[4] = 1'b1;
      tick(2);
      RAW[4] = 1'b0;
      tick(3);
    end
    check("chatter_set", CHATTER, 6'b010000);
    check("s5_held_low", s_vec, 6'b000001);
    RAW[4] = 1'b1;
    tick(6);
    check("s5_settled", s_vec, 6'b010001);
    check("chatter_sticky", CHATTER, 6'b010000);

    // Simultaneous channels
    RAW = 6'b000000;
    tick(10);
    check("all_low", s_vec, 0);
    RAW = 6'b110001;
    tick(6);
    check("simul_s", s_vec, 6'b110001);
    check("simul_chg", CHG, 6'b110001);
    tick(1);
    check("simul_chg_clear", CHG, 0);

    // Reset in the middle of a debounce
    RAW = 6'b000000;
    tick(10);
    RAW = 6'b000100;
    tick(3);
    Reset = 1'b0;
    tick(1);
    check("rst_mid_outputs", {s_vec, CHG, VALID, CHATTER}, 32'h0);
    tick(1);
    Reset = 1'b1;
    tick(5);
    check("s3_pre", s_vec, 0);
    check("valid_pre2", VALID, 0);
    tick(1);
    check("s3_after", s_vec, 6'b000100);
    check("s3_chg", CHG, 6'b000100);
    check("valid_post2", VALID, 1);
    tick(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sensor_debounce.md
Name: sensor_debounce

Overview:
- Upstream conditioning stage for the drawbridge controller (state_flat).
- Takes the six raw, asynchronous, mechanically bouncing bridge/vehicle sensors and synchronises each to Clock.
- Debounces each sensor with a per-channel stability counter and drives clean S1..S6 directly into state_flat.
- Also flags chattering sensors and signals when the outputs are trustworthy after reset.

Parameters:
- DEB_CYCLES, 4, consecutive synchronised samples differing from the current output required to accept a change; legal range 2..2**CNT_W.
- CNT_W, 4, width of each per-channel stability counter.
- CHATTER_MAX, 3, number of rejected bounces (saturating) that sets the sticky CHATTER bit for a channel.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- RAW  input  6  raw sensor levels; bit0=S1 ... bit5=S6; asynchronous to Clock.
- S1..S6  output  1 each  debounced sensor levels to state_flat.
- CHG  output  6  one-cycle pulse on the cycle a channel's debounced output changes; same bit order as RAW.
- VALID  output  1  high once post-reset settling is complete.
- CHATTER  output  6  sticky per-channel chatter flag.

Behaviour:
- Clocking and reset (already decided): one clock, Clock. Reset is asynchronous and active-low (Reset=0 resets immediately, independent of Clock).
- Reset values: S1..S6=0, CHG=0, VALID=0, CHATTER=0. Also reset to 0: sync flops, counters, bounce counters, startup counter.
- Reset mid-operation: all state clears at once; a debounce in progress is discarded and no CHG pulse is produced.
- Synchroniser: two flops per channel (sync1 then sync2). All decisions use sync2 only.
- Per channel, evaluated each rising edge (stable = the current S output):
  - sync2 != stable and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - sync2 != stable and cnt == DEB_CYCLES-1: stable <= sync2; cnt <= 0; CHG bit <= 1 for exactly one cycle; bounce_cnt <= 0.
  - sync2 == stable and cnt != 0: this is a rejected bounce. cnt <= 0; bounce_cnt <= bounce_cnt+1, saturating at CHATTER_MAX. When bounce_cnt reaches CHATTER_MAX, CHATTER bit <= 1.
  - sync2 == stable and cnt == 0: hold.
- CHATTER is cleared only by Reset.
- Latency: RAW steady from capturing edge k means the output changes at edge k+DEB_CYCLES+1. For DEB_CYCLES=4, RAW set before edge 1 gives the output update at edge 6 and CHG high during the cycle after edge 6.
- Pulses shorter than DEB_CYCLES synchronised samples never reach S outputs.
- Rejection boundary: a pulse of exactly DEB_CYCLES samples is accepted; DEB_CYCLES-1 samples is rejected.
- Channels are fully independent. Simultaneous changes on several channels give simultaneous CHG bits.
- Back-to-back edge: a change accepted on a cycle where sync2 already reverted is not possible, because acceptance uses the current sync2. The reverse transition then starts counting on the next edge with cnt=0.
- VALID: a startup counter counts edges after Reset release. VALID <= 1 at edge DEB_CYCLES+2 and stays high until the next reset. S outputs are not blocked before VALID.
- Width rules:
  - cnt is CNT_W bits.
  - bounce_cnt is clog2(CHATTER_MAX+1) bits, saturating.
  - Startup counter must hold DEB_CYCLES+2 without wrap.

Decomposition:
- Shared package (bridge_pkg) holds:
  - NUM_SENSORS=6.
  - Sensor index constants S1_IDX..S6_IDX (0..5).
  - Default DEB_CYCLES/CNT_W/CHATTER_MAX values shared with the top-level integration.
- One sub-module, sensor_debounce_ch. It contains a single channel: synchroniser, stability counter, bounce counter, CHG pulse and CHATTER flag.
- sensor_debounce instantiates six sensor_debounce_ch in a generate loop, adds the startup/VALID counter, and maps bits to S1..S6.

Test Plan (DEB_CYCLES=4, CHATTER_MAX=3 unless stated):
- Reset and VALID: Reset low 3 cycles, release, RAW=6'b000000 → all outputs 0 during reset; VALID rises at edge 6 after release; CHG stays 0.
- Clean accept: RAW[0] 0→1 before edge 1, held → S1=1 after edge 6; CHG=6'b000001 for one cycle only; other S unchanged.
- Glitch rejection: RAW[1]=1 for exactly 3 synchronised samples, then 0 → S2 stays 0; CHG=0; CHATTER[1]=0. Repeat with 4 samples → S2=1.
- Chatter: 3 separate 2-cycle pulses on RAW[4], 5 cycles apart → S5 stays 0; CHATTER=6'b010000 after the third rejected bounce; it persists after RAW[4] settles high and S5 goes 1.
- Simultaneous channels: RAW 6'b000000→6'b110001 in one cycle → S1, S5, S6 all go 1 on the same edge; CHG=6'b110001 for one cycle.
- Reset mid-debounce: RAW[2] 0→1, Reset asserted after edge 3 (before acceptance), released 2 cycles later with RAW[2] still 1 → S3=0 throughout reset; S3=1 exactly DEB_CYCLES+2 edges after release; no CHG during reset.
